// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the single port of the emulated-ROM block RAM between
// the host bus (absolute priority, serviced every cycle chip-select is low) and an
// auxiliary loader/readback port that only uses idle slots via req/ack.
// Optional feature macro: ROM_ARB_WRPROT_EN adds a wr_lock input that rejects
// auxiliary writes (aux_err=1, RAM untouched). Without it aux_err is constant 0.
module rom_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_cs_n,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_oe,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_wdata,
`ifdef ROM_ARB_WRPROT_EN
  input  logic                  wr_lock,
`endif
  output logic                  aux_ack,
  output logic [DATA_WIDTH-1:0] aux_rdata,
  output logic                  aux_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {A_IDLE, A_RDWAIT, A_ACK} aux_state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_BUS, TAG_AUX_RD} tag_t;

  aux_state_t            state;
  tag_t                  tag;
  logic                  gnt_bus;
  logic                  gnt_aux;
  logic                  wr_blocked;
  logic [ADDR_WIDTH-1:0] addr_q;

`ifdef ROM_ARB_WRPROT_EN
  assign wr_blocked = wr_lock;
`else
  assign wr_blocked = 1'b0;
`endif

  // Per-cycle grant: bus first, aux only into an idle slot with an idle FSM
  always_comb begin
    gnt_bus = ~bus_cs_n;
    gnt_aux = bus_cs_n & aux_req & (state == A_IDLE);
  end

  // RAM port steering; the address holds its last value when nobody is granted
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = aux_wdata;
    if (gnt_bus) begin
      mem_addr = bus_addr;
    end else if (gnt_aux) begin
      mem_addr = aux_addr;
      mem_we   = rst_n & aux_we & ~wr_blocked;
    end
  end

  // Remember the last driven RAM address for idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= mem_addr;
  end

  // Read tag pipeline and steering of returned RAM data to the right consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag       <= TAG_NONE;
      bus_data  <= '0;
      bus_oe    <= 1'b0;
      aux_rdata <= '0;
    end else begin
      if (gnt_bus)                 tag <= TAG_BUS;
      else if (gnt_aux && !aux_we) tag <= TAG_AUX_RD;
      else                         tag <= TAG_NONE;
      if (tag == TAG_BUS)    bus_data  <= mem_rdata;
      if (tag == TAG_AUX_RD) aux_rdata <= mem_rdata;
      // release wins over a capture landing in the same cycle
      if (bus_cs_n)            bus_oe <= 1'b0;
      else if (tag == TAG_BUS) bus_oe <= 1'b1;
    end
  end

  // Aux transaction FSM; aux_ack is registered and pulses for the A_ACK cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= A_IDLE;
      aux_ack <= 1'b0;
    end else begin
      case (state)
        A_IDLE: begin
          aux_ack <= 1'b0;
          if (gnt_aux) begin
            if (aux_we) begin
              state   <= A_ACK;
              aux_ack <= 1'b1;
            end else begin
              state <= A_RDWAIT;
            end
          end
        end
        A_RDWAIT: begin
          state   <= A_ACK;
          aux_ack <= 1'b1;
        end
        A_ACK: begin
          state   <= A_IDLE;
          aux_ack <= 1'b0;
        end
        default: begin
          state   <= A_IDLE;
          aux_ack <= 1'b0;
        end
      endcase
    end
  end

`ifdef ROM_ARB_WRPROT_EN
  logic err_q;

  // A write always acks the cycle after its grant, so the reject flag lines up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= gnt_aux & aux_we & wr_lock;
  end

  assign aux_err = err_q;
`else
  assign aux_err = 1'b0;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: scoreboard bench for rom_port_arbiter. A behavioural RAM
// stands behind the DUT; a shadow image plus per-cycle bus history predict every
// host and aux response. Build with ROM_ARB_WRPROT_EN to also exercise wr_lock.
module tb_rom_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int HN = 8192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bus_cs_n = 1'b1;
  logic [AW-1:0] bus_addr = '0;
  logic [DW-1:0] bus_data;
  logic          bus_oe;
  logic          aux_req = 1'b0;
  logic          aux_we = 1'b0;
  logic [AW-1:0] aux_addr = '0;
  logic [DW-1:0] aux_wdata = '0;
  logic          wr_lock = 1'b0;
  logic          aux_ack;
  logic [DW-1:0] aux_rdata;
  logic          aux_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int chk = 0;
  int errs = 0;

  rom_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_cs_n(bus_cs_n), .bus_addr(bus_addr), .bus_data(bus_data), .bus_oe(bus_oe),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
`ifdef ROM_ARB_WRPROT_EN
    .wr_lock(wr_lock),
`endif
    .aux_ack(aux_ack), .aux_rdata(aux_rdata), .aux_err(aux_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM behind the port, and the reference image
  logic [DW-1:0] ram    [65536];
  logic [DW-1:0] shadow [65536];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic bit lock_on();
`ifdef ROM_ARB_WRPROT_EN
    return wr_lock;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model state: bus grant history per cycle and pending aux completions
  typedef struct {int due; bit rd; logic [DW-1:0] data; bit err;} aux_exp_t;
  aux_exp_t      aux_q[$];
  bit            glow [HN];
  logic [DW-1:0] gval [HN];
  int            cyc = 0;
  int            rmark = 0;
  int            busy_until = -1;

  // Host sees the value of its most recent granted read at least two cycles old
  function automatic logic [DW-1:0] exp_bus_data(int t);
    for (int s = t - 2; s >= rmark; s--)
      if (glow[s]) return gval[s];
    return '0;
  endfunction

  // Pads drive once chip-select has been low for the previous two cycles
  function automatic bit exp_bus_oe(int t);
    if (t < 2 || t - 2 < rmark) return 1'b0;
    return glow[t-1] && glow[t-2];
  endfunction

  // Model update at the end of each cycle from the inputs the bench drove
  always @(posedge clk) begin
    aux_exp_t e;
    int c;
    c = cyc;
    if (c >= HN - 1) begin
      $display("FAIL cycle_budget: cycle %0d, limit %0d", c, HN - 1);
      $fatal(1, "cycle budget exhausted");
    end
    if (!rst_n) begin
      glow[c] = 1'b0;
      if (c > 0) glow[c-1] = 1'b0;
      rmark = c + 1;
      busy_until = c;
      aux_q.delete();
    end else begin
      glow[c] = !bus_cs_n;
      gval[c] = shadow[bus_addr];
      if (bus_cs_n && aux_req && c > busy_until) begin
        e.rd   = !aux_we;
        e.due  = c + (aux_we ? 1 : 2);
        e.data = shadow[aux_addr];
        e.err  = 1'b0;
        if (aux_we) begin
          if (lock_on()) e.err = 1'b1;
          else shadow[aux_addr] = aux_wdata;
        end
        busy_until = e.due;
        aux_q.push_back(e);
      end
    end
    cyc = c + 1;
  end

  // Monitor: compares DUT outputs mid-cycle against the model
  always @(negedge clk) begin
    int t;
    bit g_aux;
    bit e_we;
    logic [DW-1:0] ed;
    aux_exp_t e;
    t = cyc;
    if (!rst_n) begin
      chk++;
      if ({bus_data, bus_oe, aux_ack, aux_rdata, aux_err, mem_we} != '0) begin
        errs++;
        $display("FAIL reset_outputs: cycle %0d got data=%h oe=%b ack=%b rdata=%h err=%b we=%b, want all 0",
                 t, bus_data, bus_oe, aux_ack, aux_rdata, aux_err, mem_we);
      end
    end else begin
      ed = exp_bus_data(t);
      chk++;
      if (bus_oe !== exp_bus_oe(t)) begin
        errs++;
        $display("FAIL bus_oe: cycle %0d got %b want %b", t, bus_oe, exp_bus_oe(t));
      end
      chk++;
      if (bus_data !== ed) begin
        errs++;
        $display("FAIL bus_data: cycle %0d got %h want %h", t, bus_data, ed);
      end
      g_aux = bus_cs_n && aux_req && (t > busy_until);
      e_we  = g_aux && aux_we && !lock_on();
      chk++;
      if (mem_we !== e_we) begin
        errs++;
        $display("FAIL mem_we: cycle %0d got %b want %b (cs_n=%b)", t, mem_we, e_we, bus_cs_n);
      end
      if (!bus_cs_n || g_aux) begin
        chk++;
        if (mem_addr !== (!bus_cs_n ? bus_addr : aux_addr)) begin
          errs++;
          $display("FAIL mem_addr: cycle %0d got %h want %h", t, mem_addr,
                   (!bus_cs_n ? bus_addr : aux_addr));
        end
      end
      if (aux_q.size() > 0 && aux_q[0].due == t) begin
        e = aux_q.pop_front();
        chk++;
        if (aux_ack !== 1'b1) begin
          errs++;
          $display("FAIL aux_ack_missing: cycle %0d got ack=%b want 1", t, aux_ack);
        end else begin
          chk++;
          if (aux_err !== e.err) begin
            errs++;
            $display("FAIL aux_err: cycle %0d got %b want %b", t, aux_err, e.err);
          end
          if (e.rd) begin
            chk++;
            if (aux_rdata !== e.data) begin
              errs++;
              $display("FAIL aux_rdata: cycle %0d got %h want %h", t, aux_rdata, e.data);
            end
          end
        end
      end else if (aux_ack) begin
        chk++;
        errs++;
        $display("FAIL aux_ack_unexpected: cycle %0d got ack=1 want 0", t);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One aux transaction with the req/ack handshake, bounded wait
  task automatic aux_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    aux_we = we; aux_addr = a; aux_wdata = d; aux_req = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      tick();
      if (aux_ack) done = 1'b1;
    end
    aux_req = 1'b0;
    if (!done) begin
      chk++;
      errs++;
      $display("FAIL aux_timeout: addr %h got no ack within 200 cycles, want ack", a);
    end
    tick();
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input int n);
    bus_cs_n = 1'b0;
    bus_addr = a;
    repeat (n) tick();
    bus_cs_n = 1'b1;
  endtask

  bit rnd_done;

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = DW'($urandom);
      ram[i] = v;
      shadow[i] = v;
    end
    ram[16'h1234] = 8'hA5; shadow[16'h1234] = 8'hA5;
    ram[16'h0001] = 8'h11; shadow[16'h0001] = 8'h11;
    ram[16'h0040] = 8'h22; shadow[16'h0040] = 8'h22;
    ram[16'h0300] = 8'h00; shadow[16'h0300] = 8'h00;

    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Host read of 0x1234, held three cycles, then release
    bus_read(16'h1234, 3);
    repeat (3) tick();

    // Aux write then read back
    aux_op(1'b1, 16'h0200, 8'h5A);
    aux_op(1'b0, 16'h0200, 8'h00);

    // Contention: aux waits out ten host cycles
    fork
      begin
        bus_cs_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
          bus_addr = AW'($urandom_range(0, 255));
          tick();
        end
        bus_cs_n = 1'b1;
      end
      begin
        tick();
        aux_op(1'b1, 16'h0080, 8'h3C);
      end
    join
    aux_op(1'b0, 16'h0080, 8'h00);

    // Interleave: aux read granted, host takes the next cycles
    fork
      aux_op(1'b0, 16'h0040, 8'h00);
      begin
        tick();
        bus_read(16'h0001, 3);
      end
    join
    repeat (2) tick();

    // Reset in the middle of an aux read: no ack may follow
    aux_we = 1'b0; aux_addr = 16'h0010; aux_req = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    aux_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    aux_op(1'b0, 16'h0010, 8'h00);

`ifdef ROM_ARB_WRPROT_EN
    wr_lock = 1'b1;
    aux_op(1'b1, 16'h0300, 8'hFF);
    wr_lock = 1'b0;
    aux_op(1'b0, 16'h0300, 8'h00);
`endif

    // Randomized mix of host traffic and aux operations on a small address window
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          bus_cs_n = ($urandom_range(0, 9) < 5);
          bus_addr = AW'($urandom_range(0, 15));
          tick();
        end
        bus_cs_n = 1'b1;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
`ifdef ROM_ARB_WRPROT_EN
          wr_lock = ($urandom_range(0, 3) == 0);
`endif
          aux_op(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
          repeat ($urandom_range(0, 2)) tick();
        end
      end
    join
    wr_lock = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", chk, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
